mem_read_arbiter: RTL and testbench

- Shares the single AXI read-address/read-data channel to memory between the instruction-cache refill engine (port 0) and the data-cache refill engine (port 1).
- Serialises line-refill bursts, one outstanding burst at a time.
- Routes returning beats only to the granted requester.
- Sits between both caches and the memory controller in mips_core.

---
 rtl/mem_read_arbiter_if.sv | 44 ++++
 rtl/mem_read_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// Bus bundle for mem_read_arbiter: two cache refill requesters (m_*) and the
// shared AXI-style read-address/read-data channel to the memory controller (s_*).
// The 'master' modport is the arbiter's view (it masters the memory channel);
// the 'slave' modport is the surrounding caches/memory view.
interface mem_read_arbiter_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 5
) ();

  // Requester side, index 0 = icache refill, index 1 = dcache refill
  logic [ADDR_W-1:0] m_araddr [0:1];
  logic [LEN_W-1:0]  m_arlen  [0:1];
  logic [1:0]        m_arvalid;
  logic [1:0]        m_arready;
  logic [DATA_W-1:0] m_rdata  [0:1];
  logic [1:0]        m_rvalid;
  logic [1:0]        m_rready;

  // Memory side
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic [3:0]        s_arid;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    input  s_arready, s_rdata, s_rvalid,
    output m_arready, m_rdata, m_rvalid,
    output s_araddr, s_arlen, s_arid, s_arvalid, s_rready
  );

  modport slave (
    output m_araddr, m_arlen, m_arvalid, m_rready,
    output s_arready, s_rdata, s_rvalid,
    input  m_arready, m_rdata, m_rvalid,
    input  s_araddr, s_arlen, s_arid, s_arvalid, s_rready
  );

endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one memory read channel between the icache (port 0)
// and dcache (port 1) refill engines. One burst outstanding at a time; returning
// beats are steered only to the granted requester.
// Optional build macro MEM_ARB_DCACHE_PRIORITY_EN: when defined, port 1 always
// wins simultaneous requests (fixed priority, no round-robin pointer); when
// undefined, simultaneous requests alternate round-robin.
module mem_read_arbiter #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_read_arbiter_if.master  bus_io,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
  logic              rr_ptr_q, rr_ptr_d;
`endif

  logic              any_req;
  logic              winner;
  logic              r_hs;
  logic              last_beat;
  logic [LEN_W-1:0]  win_len;

  assign any_req   = |bus_io.m_arvalid;
  assign r_hs      = bus_io.s_rvalid & bus_io.s_rready;
  assign last_beat = (beat_cnt_q == (len_q - LenOne));

  // Arbitration: pick the requester to grant from the IDLE state
  always_comb begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    winner = bus_io.m_arvalid[1];
`else
    if (bus_io.m_arvalid[rr_ptr_q]) begin
      winner = rr_ptr_q;
    end else begin
      winner = ~rr_ptr_q;
    end
`endif
  end

  // A zero beat count still fetches one beat so the burst always terminates
  always_comb begin
    win_len = bus_io.m_arlen[winner];
    if (win_len == '0) begin
      win_len = LenOne;
    end
  end

  // Next-state logic for the burst FSM and latched request
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = winner;
          addr_d  = bus_io.m_araddr[winner];
          len_d   = win_len;
          state_d = StAddr;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
          rr_ptr_d = ~winner;
`endif
        end
      end
      StAddr: begin
        if (bus_io.s_arready) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + LenOne;
          if (last_beat) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; synchronous reset aborts any burst in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Memory-side address channel driven from the latched request
  always_comb begin
    bus_io.s_araddr  = addr_q;
    bus_io.s_arlen   = len_q;
    bus_io.s_arid    = {3'b000, grant_q};
    bus_io.s_arvalid = (state_q == StAddr);
  end

  // Address-accept steering: only the granted requester ever sees ARREADY
  always_comb begin
    bus_io.m_arready = 2'b00;
    if (state_q == StAddr) begin
      bus_io.m_arready[grant_q] = bus_io.s_arready;
    end
  end

  // Read-data steering; memory beats outside DATA are neither accepted nor forwarded
  always_comb begin
    bus_io.m_rdata[0] = bus_io.s_rdata;
    bus_io.m_rdata[1] = bus_io.s_rdata;
    bus_io.m_rvalid   = 2'b00;
    bus_io.s_rready   = 1'b0;
    if (state_q == StData) begin
      bus_io.m_rvalid[grant_q] = bus_io.s_rvalid;
      bus_io.s_rready          = bus_io.m_rready[grant_q];
    end
  end

  // Status outputs
  always_comb begin
    busy     = (state_q != StIdle);
    grant_id = grant_q;
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit later, away from the edge.
module tb_mem_read_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic grant_id;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
  localparam bit FirstA = 1'b1;  // first contention round
  localparam bit FirstB = 1'b1;  // second contention round
`else
  localparam bit FirstA = 1'b0;
  localparam bit FirstB = 1'b1;
`endif

  always #5 clk = ~clk;

  mem_read_arbiter_if #(.ADDR_W(26), .DATA_W(32), .LEN_W(5)) bus ();

  mem_read_arbiter #(.ADDR_W(26), .DATA_W(32), .LEN_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_io   (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge into ADDR; leaves just after the edge into DATA
  task automatic addr_phase(input bit p, input logic [25:0] addr, input logic [4:0] len);
    #1;
    chk("ar_valid", 32'(bus.s_arvalid), 32'd1);
    chk("ar_addr", 32'(bus.s_araddr), 32'(addr));
    chk("ar_len", 32'(bus.s_arlen), 32'(len));
    chk("ar_id", 32'(bus.s_arid), 32'(p));
    chk("grant", 32'(grant_id), 32'(p));
    chk("busy_addr", 32'(busy), 32'd1);
    chk("arready_wait", 32'(bus.m_arready), 32'd0);
    step();
    bus.s_arready = 1'b1;
    #1;
    chk("arready_grant", 32'(bus.m_arready), (p ? 32'd2 : 32'd1));
    step();
    bus.s_arready    = 1'b0;
    bus.m_arvalid[p] = 1'b0;
  endtask

  // One accepted beat to port p
  task automatic beat(input bit p, input logic [31:0] d);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = d;
    #1;
    chk("rvalid", 32'(bus.m_rvalid), (p ? 32'd2 : 32'd1));
    chk("rdata", bus.m_rdata[p], d);
    chk("s_rready", 32'(bus.s_rready), 32'd1);
    chk("arready_data", 32'(bus.m_arready), 32'd0);
    step();
    bus.s_rvalid = 1'b0;
  endtask

  task automatic idle_chk();
    #1;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rvalid_idle", 32'(bus.m_rvalid), 32'd0);
    chk("s_rready_idle", 32'(bus.s_rready), 32'd0);
    chk("arvalid_idle", 32'(bus.s_arvalid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.m_araddr[0] = '0;
    bus.m_araddr[1] = '0;
    bus.m_arlen[0]  = '0;
    bus.m_arlen[1]  = '0;
    bus.m_arvalid   = 2'b00;
    bus.m_rready    = 2'b11;
    bus.s_arready   = 1'b1;
    bus.s_rvalid    = 1'b1;
    bus.s_rdata     = 32'h0;

    // Reset state, with memory handshakes asserted that must be ignored
    step();
    step();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_arvalid", 32'(bus.s_arvalid), 32'd0);
    chk("rst_rready", 32'(bus.s_rready), 32'd0);
    chk("rst_arready", 32'(bus.m_arready), 32'd0);
    chk("rst_rvalid", 32'(bus.m_rvalid), 32'd0);
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b0;
    rst_n         = 1'b1;
    step();

    // Single request from port 0
    bus.m_araddr[0] = 26'h0000100;
    bus.m_arlen[0]  = 5'd4;
    bus.m_arvalid[0] = 1'b1;
    #1;
    chk("idle_no_arready", 32'(bus.m_arready), 32'd0);
    chk("idle_no_arvalid", 32'(bus.s_arvalid), 32'd0);
    step();
    addr_phase(1'b0, 26'h0000100, 5'd4);
    for (int i = 0; i < 4; i++) beat(1'b0, 32'hA0 + 32'(i));
    idle_chk();

    // Reset during beat 2 of a port 1 burst
    step();
    bus.m_araddr[1] = 26'h0000500;
    bus.m_arlen[1]  = 5'd4;
    bus.m_arvalid[1] = 1'b1;
    step();
    addr_phase(1'b1, 26'h0000500, 5'd4);
    beat(1'b1, 32'hC0);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'hC1;
    rst_n        = 1'b0;
    step();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rready", 32'(bus.s_rready), 32'd0);
    chk("mid_rst_rvalid", 32'(bus.m_rvalid), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    rst_n        = 1'b1;
    bus.s_rvalid = 1'b0;
    step();

    // Contention straight after reset
    bus.m_araddr[0] = 26'h0000200;
    bus.m_araddr[1] = 26'h0000300;
    bus.m_arlen[0]  = 5'd4;
    bus.m_arlen[1]  = 5'd4;
    bus.m_arvalid   = 2'b11;
    step();
    addr_phase(FirstA, FirstA ? 26'h0000300 : 26'h0000200, 5'd4);
    for (int i = 0; i < 4; i++) beat(FirstA, 32'h10 + 32'(i));
    idle_chk();
    step();
    addr_phase(~FirstA, FirstA ? 26'h0000200 : 26'h0000300, 5'd4);
    for (int i = 0; i < 4; i++) beat(~FirstA, 32'h20 + 32'(i));
    idle_chk();

    // Zero beat count is treated as a single beat
    step();
    bus.m_araddr[0] = 26'h0000040;
    bus.m_arlen[0]  = 5'd0;
    bus.m_arvalid[0] = 1'b1;
    step();
    addr_phase(1'b0, 26'h0000040, 5'd1);
    beat(1'b0, 32'h55);
    idle_chk();

    // Second contention round; pointer now favours port 1
    step();
    bus.m_araddr[0] = 26'h0000200;
    bus.m_araddr[1] = 26'h0000300;
    bus.m_arlen[0]  = 5'd4;
    bus.m_arlen[1]  = 5'd4;
    bus.m_arvalid   = 2'b11;
    step();
    addr_phase(FirstB, FirstB ? 26'h0000300 : 26'h0000200, 5'd4);
    for (int i = 0; i < 4; i++) beat(FirstB, 32'h30 + 32'(i));
    idle_chk();
    step();
    addr_phase(~FirstB, FirstB ? 26'h0000200 : 26'h0000300, 5'd4);
    for (int i = 0; i < 4; i++) beat(~FirstB, 32'h40 + 32'(i));
    idle_chk();

    // Backpressure on port 1 with memory data waiting
    step();
    bus.m_araddr[1] = 26'h0000800;
    bus.m_arlen[1]  = 5'd2;
    bus.m_arvalid[1] = 1'b1;
    step();
    addr_phase(1'b1, 26'h0000800, 5'd2);
    bus.m_rready = 2'b01;
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'hF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rvalid", 32'(bus.m_rvalid), 32'd2);
      chk("bp_s_rready", 32'(bus.s_rready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      step();
    end
    bus.m_rready = 2'b11;
    beat(1'b1, 32'hF0);
    #1;
    chk("bp_busy_mid", 32'(busy), 32'd1);
    beat(1'b1, 32'hF1);
    idle_chk();

    // Port 1 requests while port 0's burst is in DATA
    step();
    bus.m_araddr[0] = 26'h0000600;
    bus.m_arlen[0]  = 5'd2;
    bus.m_arvalid[0] = 1'b1;
    step();
    addr_phase(1'b0, 26'h0000600, 5'd2);
    bus.m_araddr[1] = 26'h0000700;
    bus.m_arlen[1]  = 5'd1;
    bus.m_arvalid[1] = 1'b1;
    beat(1'b0, 32'hD0);
    beat(1'b0, 32'hD1);
    idle_chk();
    chk("late_arready_idle", 32'(bus.m_arready), 32'd0);
    step();
    addr_phase(1'b1, 26'h0000700, 5'd1);
    beat(1'b1, 32'hE0);
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
